mem_bus_interface: RTL and testbench
====================================

Name: mem_bus_interface

Overview:
Memory bus interface unit sitting between the control unit and the external bus. It turns the control unit's one-bit memory read/write micro-orders, together with the MAR/MBR contents, into a registered request/acknowledge transaction on the external memory bus. It returns read data to the MBR and stalls the control-address sequencer with o_busy until each access completes. A missing acknowledge is trapped by a timeout that freezes the core and raises a bus error.

Parameters:
ADDR_W, 8, width of MAR and external address bus
DATA_W, 16, width of MBR and external data bus
TIMEOUT, 15, maximum cycles in an access state without i_mem_ack before the error trap (1..255)

Ports:
i_clk  input  1  system clock, all state updated on rising edge
i_rst  input  1  asynchronous, active-high reset
i_rd_req  input  1  read micro-order from CU; held by CU while o_busy=1
i_wr_req  input  1  write micro-order from CU; held by CU while o_busy=1
i_mar_data  input  ADDR_W  MAR contents, sampled at issue
i_mbr_data  input  DATA_W  MBR contents (write data), sampled at issue
o_mbr_data  output  DATA_W  read data captured from memory
o_mbr_load  output  1  one-cycle strobe: o_mbr_data valid, MBR loads
o_busy  output  1  stall to CAR; CU holds its current control word while high
o_bus_err  output  1  sticky bus error flag, feeds halt logic
o_mem_addr  output  ADDR_W  external address, registered
o_mem_wdata  output  DATA_W  external write data, registered
o_mem_rd  output  1  external read strobe, level, held until ack
o_mem_wr  output  1  external write strobe, level, held until ack
i_mem_rdata  input  DATA_W  external read data, valid with i_mem_ack
i_mem_ack  input  1  external acknowledge, one cycle or longer

Behaviour:
- Interface: one clock (i_clk); reset i_rst is asynchronous and active-high. While i_rst=1, every output is 0 and the state is IDLE. The timeout counter and captured data are cleared. Reset mid-access aborts the access: strobes drop immediately and no o_mbr_load is issued.
- States:
  - IDLE: on i_rd_req, register i_mar_data into o_mem_addr and go to RD. On i_wr_req, register i_mar_data into o_mem_addr and i_mbr_data into o_mem_wdata, then go to WR. If both requests are 1, this is a protocol error: go to ERR, no strobe.
  - RD: o_mem_rd=1. On i_mem_ack, capture i_mem_rdata into o_mbr_data and go to DONE.
  - WR: o_mem_wr=1. On i_mem_ack, go to DONE.
  - DONE: o_mbr_load=1 for one cycle if the access was a read. Unconditionally return to IDLE. Requests seen here belong to the completed control word and are ignored.
  - ERR: terminal until reset. o_bus_err=1, o_busy=1, strobes 0.
- o_busy (combinational): 1 in RD, WR and ERR. Also 1 in IDLE when i_rd_req or i_wr_req is 1, so the request cycle itself stalls. 0 in DONE.
- Timing: request first seen at cycle N; strobe high from N+1; ack at cycle M. At M+1 the state is DONE, o_busy=0 and o_mbr_load=1; the CU advances at the next edge. Minimum latency is ack at N+1, giving completion at N+2. Back-to-back accesses cost 3 cycles each.
- Timeout: an 8-bit counter clears on entry to RD/WR and increments each cycle without ack. If the counter equals TIMEOUT-1 and ack is absent, go to ERR on the next edge. An ack in that same cycle wins and completes normally.
- i_mem_ack in IDLE, DONE or ERR is spurious and ignored; no state change.
- o_mem_addr and o_mem_wdata hold their last value after an access; they change only at issue.
- i_mar_data and i_mbr_data changing while busy has no effect.

Decomposition:
- Package mem_bus_pkg: state enumeration (IDLE, RD, WR, DONE, ERR), default widths, timeout counter width.
- One sub-module: bus_timeout_counter (clear, enable, terminal-count compare against TIMEOUT, expired output).

Test Plan:
- Read, ack 2 cycles after strobe: i_rd_req=1, MAR=0x3C, memory returns 0xBEEF. Expect o_mem_addr=0x3C and o_mem_rd=1 from N+1. Expect o_mbr_data=0xBEEF with o_mbr_load=1 for exactly one cycle. o_busy must be high from N through ack+0, and low in the DONE cycle.
- Write, ack same cycle as strobe onset: i_wr_req=1, MAR=0x05, MBR=0x1234. Expect o_mem_wdata=0x1234 with o_mem_wr=1 for one cycle. Expect completion at N+2 and no o_mbr_load.
- Timeout: i_rd_req=1, no ack, TIMEOUT=15. Expect o_mem_rd held 15 cycles, then ERR. Expect o_bus_err=1, o_busy=1, strobes 0, and ERR held until i_rst.
- Ack on last timeout cycle: ack in the 15th strobe cycle. Expect normal completion and o_bus_err=0.
- Protocol error and spurious ack: i_rd_req=i_wr_req=1 in IDLE -> ERR, no strobe. Separately, i_mem_ack pulsed in IDLE -> no output change.
- Reset mid-access: assert i_rst during RD. Expect all outputs 0 asynchronously and no o_mbr_load. Expect a fresh read to work after deassertion.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default sizes for the memory bus interface unit.
package mem_bus_pkg;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;
  localparam int TO_CNT_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/bus_timeout_counter.sv
// Counts access cycles without acknowledge; flags the last allowed cycle.
module bus_timeout_counter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [TO_CNT_W-1:0] TC = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  // Terminal count: the caller decides whether an ack in this cycle wins.
  assign o_expired = (r_cnt == TC);
endmodule

// File: rtl/mem_bus_interface.sv
// Turns CU read/write micro-orders into a registered req/ack memory bus
// transaction, stalls the sequencer while busy and traps missing acks.
module mem_bus_interface
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_mar_data,
  input  logic [DATA_W-1:0] i_mbr_data,
  output logic [DATA_W-1:0] o_mbr_data,
  output logic              o_mbr_load,
  output logic              o_busy,
  output logic              o_bus_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack
);
  state_e             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_is_rd;
  logic               w_access;
  logic               w_expired;
  logic               w_issue_rd;
  logic               w_issue_wr;

  assign w_access   = (r_state == S_RD) || (r_state == S_WR);
  assign w_issue_rd = (r_state == S_IDLE) && i_rd_req && !i_wr_req;
  assign w_issue_wr = (r_state == S_IDLE) && i_wr_req && !i_rd_req;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (!w_access),
    .i_en      (w_access && !i_mem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mbr_load = 1'b0;
    o_bus_err  = 1'b0;
    o_busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The request cycle itself stalls; gated so reset forces all-zero outputs.
        o_busy = (i_rd_req || i_wr_req) && !i_rst;
        if (i_rd_req && i_wr_req) w_next = S_ERR;
        else if (i_rd_req)        w_next = S_RD;
        else if (i_wr_req)        w_next = S_WR;
      end
      S_RD: begin
        o_mem_rd = 1'b1;
        o_busy   = 1'b1;
        if (i_mem_ack)      w_next = S_DONE;
        else if (w_expired) w_next = S_ERR;
      end
      S_WR: begin
        o_mem_wr = 1'b1;
        o_busy   = 1'b1;
        if (i_mem_ack)      w_next = S_DONE;
        else if (w_expired) w_next = S_ERR;
      end
      S_DONE: begin
        o_mbr_load = r_is_rd;
        w_next     = S_IDLE;
      end
      S_ERR: begin
        o_bus_err = 1'b1;
        o_busy    = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_is_rd <= 1'b0;
    end else begin
      if (w_issue_rd) begin
        r_addr  <= i_mar_data;
        r_is_rd <= 1'b1;
      end
      if (w_issue_wr) begin
        r_addr  <= i_mar_data;
        r_wdata <= i_mbr_data;
        r_is_rd <= 1'b0;
      end
      if (r_state == S_RD && i_mem_ack) r_rdata <= i_mem_rdata;
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mbr_data  = r_rdata;
endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed-vector bench for mem_bus_interface with hand-computed expectations.
module tb_mem_bus_interface;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [7:0]  mar;
  logic [15:0] mbr;
  logic [15:0] mbr_out;
  logic        mbr_load, busy, bus_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_interface #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_req    (rd_req),
    .i_wr_req    (wr_req),
    .i_mar_data  (mar),
    .i_mbr_data  (mbr),
    .o_mbr_data  (mbr_out),
    .o_mbr_load  (mbr_load),
    .o_busy      (busy),
    .o_bus_err   (bus_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic ok;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mar = '0; mbr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_strb", {mem_rd, mem_wr, mbr_load}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {mem_wdata, mbr_out}, 0);
    nxt; nxt; rst = 1'b0;

    // read, ack two cycles after strobe onset
    nxt; rd_req = 1'b1; mar = 8'h3C; #1;
    chk("rd_busyN", busy, 1);
    chk("rd_strbN", mem_rd, 0);
    nxt; #1;
    chk("rd_strb1", mem_rd, 1);
    chk("rd_addr", mem_addr, 8'h3C);
    chk("rd_busy1", busy, 1);
    mar = 8'hFF;
    nxt; #1;
    chk("rd_strb2", mem_rd, 1);
    nxt; mem_ack = 1'b1; mem_rdata = 16'hBEEF; #1;
    chk("rd_busyAck", busy, 1);
    chk("rd_loadAck", mbr_load, 0);
    nxt; mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("rd_doneBusy", busy, 0);
    chk("rd_doneLoad", mbr_load, 1);
    chk("rd_doneData", mbr_out, 16'hBEEF);
    chk("rd_doneStrb", mem_rd, 0);
    rd_req = 1'b0;
    nxt; #1;
    chk("rd_loadOnce", mbr_load, 0);
    chk("rd_addrHold", mem_addr, 8'h3C);

    // spurious ack in IDLE
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    nxt; mem_ack = 1'b0; #1;
    chk("sp_outs", {busy, mem_rd, mem_wr, mbr_load, bus_err}, 0);
    chk("sp_data", mbr_out, 16'hBEEF);

    // write, ack on strobe onset
    nxt; wr_req = 1'b1; mar = 8'h05; mbr = 16'h1234; #1;
    chk("wr_busyN", busy, 1);
    chk("wr_strbN", mem_wr, 0);
    nxt; mem_ack = 1'b1; #1;
    chk("wr_strb", mem_wr, 1);
    chk("wr_wdata", mem_wdata, 16'h1234);
    chk("wr_addr", mem_addr, 8'h05);
    nxt; mem_ack = 1'b0; #1;
    chk("wr_doneBusy", busy, 0);
    chk("wr_noLoad", mbr_load, 0);
    chk("wr_strbOff", mem_wr, 0);
    wr_req = 1'b0;
    nxt; #1;
    chk("wr_idle", {busy, mem_wr, mbr_load}, 0);

    // ack arrives on the 15th (last) strobe cycle
    nxt; rd_req = 1'b1; mar = 8'h77; #1;
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      nxt; #1;
      if (!(mem_rd && busy && !bus_err)) ok = 1'b0;
    end
    chk("lt_strb14", ok, 1);
    nxt; mem_ack = 1'b1; mem_rdata = 16'h0A0A; #1;
    chk("lt_strb15", {mem_rd, bus_err}, 2'b10);
    nxt; mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("lt_load", mbr_load, 1);
    chk("lt_data", mbr_out, 16'h0A0A);
    chk("lt_noErr", {bus_err, busy}, 0);
    rd_req = 1'b0;
    nxt;

    // timeout: no ack ever
    rd_req = 1'b1; mar = 8'h10;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      nxt; #1;
      if (mem_rd) cnt++;
      else break;
    end
    chk("to_strbCycles", cnt, 15);
    chk("to_err", bus_err, 1);
    chk("to_busy", busy, 1);
    chk("to_strbOff", {mem_rd, mem_wr, mbr_load}, 0);
    rd_req = 1'b0; mem_ack = 1'b1;
    nxt; mem_ack = 1'b0;
    nxt; nxt; #1;
    chk("to_errHold", {bus_err, busy, mem_rd}, 3'b110);
    #2; rst = 1'b1; #1;
    chk("to_rstClr", {bus_err, busy}, 0);
    chk("to_rstAddr", mem_addr, 0);
    chk("to_rstData", mbr_out, 0);
    nxt; rst = 1'b0;

    // protocol error: both requests at once
    nxt; rd_req = 1'b1; wr_req = 1'b1; mar = 8'h55; mbr = 16'hAAAA; #1;
    chk("pe_busyN", busy, 1);
    nxt; #1;
    chk("pe_err", {bus_err, mem_rd, mem_wr}, 3'b100);
    rd_req = 1'b0; wr_req = 1'b0;
    nxt; #1;
    chk("pe_hold", {bus_err, busy, mem_rd, mem_wr}, 4'b1100);
    rst = 1'b1;
    nxt; rst = 1'b0;

    // reset in the middle of a read
    nxt; rd_req = 1'b1; mar = 8'h21;
    nxt; #1;
    chk("ra_strb", mem_rd, 1);
    #2; rst = 1'b1; #1;
    chk("ra_strbOff", mem_rd, 0);
    chk("ra_busy", busy, 0);
    chk("ra_addr", mem_addr, 0);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    nxt; #1;
    chk("ra_noLoad", {mbr_load, mem_rd, busy}, 0);
    chk("ra_noData", mbr_out, 0);
    mem_ack = 1'b0; rd_req = 1'b0; rst = 1'b0;

    // fresh read after reset, minimum latency
    nxt; rd_req = 1'b1; mar = 8'h42; #1;
    chk("fr_busyN", busy, 1);
    nxt; mem_ack = 1'b1; mem_rdata = 16'h5A5A; #1;
    chk("fr_strb", mem_rd, 1);
    chk("fr_addr", mem_addr, 8'h42);
    nxt; mem_ack = 1'b0; rd_req = 1'b0; #1;
    chk("fr_load", mbr_load, 1);
    chk("fr_data", mbr_out, 16'h5A5A);
    chk("fr_busy", busy, 0);
    nxt; #1;
    chk("fr_loadOff", mbr_load, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
